// File: rtl/salamander_dpram_be.sv
// True dual-port byte-enable RAM with selectable read-during-write policy and optional output register.
// Define SALAMANDER_DPRAM_CLEAR_EN to build the post-reset clear engine (sweeps CLR_VAL, blocks both ports).
module salamander_dpram_be #(
  parameter int unsigned    AW         = 10,
  parameter int unsigned    DW         = 8,
  parameter int unsigned    RDW_MODE   = 2,
  parameter int unsigned    OUTREG     = 0,
  parameter logic [DW-1:0]  CLR_VAL    = '0,
  parameter string          simhexfile = ""
) (
  input  logic              i_MCLK,
  input  logic              i_RST,
  input  logic [AW-1:0]     i_A_ADDR,
  input  logic [DW-1:0]     i_A_DIN,
  input  logic [DW/8-1:0]   i_A_BE,
  input  logic              i_A_RD,
  input  logic              i_A_WR,
  output logic [DW-1:0]     o_A_DOUT,
  input  logic [AW-1:0]     i_B_ADDR,
  input  logic [DW-1:0]     i_B_DIN,
  input  logic [DW/8-1:0]   i_B_BE,
  input  logic              i_B_RD,
  input  logic              i_B_WR,
  output logic [DW-1:0]     o_B_DOUT,
  input  logic              i_CLR_REQ,
  output logic              o_BUSY
);

  localparam int unsigned NBE   = DW / 8;
  localparam int unsigned DEPTH = 2 ** AW;

  logic [DW-1:0] r_mem [DEPTH];
  logic [DW-1:0] r_a_q, r_b_q;

  logic          w_en;
  logic          w_clr_we;
  logic [AW-1:0] w_clr_addr;

  // Replace the byte lanes selected by be with the matching lanes of din.
  function automatic logic [DW-1:0] f_merge(input logic [DW-1:0] old_w,
                                            input logic [DW-1:0] din,
                                            input logic [NBE-1:0] be);
    logic [DW-1:0] v;
    v = old_w;
    for (int n = 0; n < int'(NBE); n++) begin
      if (be[n]) v[8*n +: 8] = din[8*n +: 8];
    end
    return v;
  endfunction

`ifdef SALAMANDER_DPRAM_CLEAR_EN
  typedef enum logic {S_CLEAR, S_READY} state_t;

  state_t        r_state;
  logic [AW-1:0] r_clr_addr;
  logic          r_busy;

  always_ff @(posedge i_MCLK or posedge i_RST) begin
    if (i_RST) begin
      r_state    <= S_CLEAR;
      r_clr_addr <= '0;
      r_busy     <= 1'b1;
    end else begin
      case (r_state)
        S_CLEAR: begin
          r_clr_addr <= r_clr_addr + AW'(1);
          if (r_clr_addr == AW'(DEPTH - 1)) begin
            r_state <= S_READY;
            r_busy  <= 1'b0;
          end
        end
        S_READY: begin
          if (i_CLR_REQ) begin
            r_state    <= S_CLEAR;
            r_clr_addr <= '0;
            r_busy     <= 1'b1;
          end
        end
        default: begin
          r_state <= S_CLEAR;
          r_busy  <= 1'b1;
        end
      endcase
    end
  end

  assign w_en       = (r_state == S_READY);
  assign w_clr_we   = (r_state == S_CLEAR);
  assign w_clr_addr = r_clr_addr;
  assign o_BUSY     = r_busy;
`else
  logic w_unused_clr_req;

  assign w_unused_clr_req = i_CLR_REQ;
  assign w_en             = 1'b1;
  assign w_clr_we         = 1'b0;
  assign w_clr_addr       = '0;
  assign o_BUSY           = 1'b0;
`endif

  logic          w_a_we, w_b_we, w_a_rd, w_b_rd, w_same;
  logic [DW-1:0] w_a_old, w_b_old, w_a_final, w_b_final;

  assign w_a_we  = i_A_WR & w_en;
  assign w_b_we  = i_B_WR & w_en;
  assign w_a_rd  = i_A_RD & w_en;
  assign w_b_rd  = i_B_RD & w_en;
  assign w_same  = (i_A_ADDR == i_B_ADDR);
  assign w_a_old = r_mem[i_A_ADDR];
  assign w_b_old = r_mem[i_B_ADDR];

  // Word as stored after this edge; on an address collision A owns every lane it enables.
  assign w_a_final = f_merge(f_merge(w_a_old, i_B_DIN, i_B_BE & {NBE{w_b_we & w_same}}),
                             i_A_DIN, i_A_BE);
  assign w_b_final = f_merge(f_merge(w_b_old, i_B_DIN, i_B_BE),
                             i_A_DIN, i_A_BE & {NBE{w_a_we & w_same}});

  always_ff @(posedge i_MCLK) begin
    if (w_clr_we) begin
      r_mem[w_clr_addr] <= CLR_VAL;
    end else begin
      if (w_a_we) r_mem[i_A_ADDR] <= w_a_final;
      if (w_b_we) r_mem[i_B_ADDR] <= w_b_final;
    end
  end

  // First read stage; the other port always sees the pre-write word.
  always_ff @(posedge i_MCLK or posedge i_RST) begin
    if (i_RST) begin
      r_a_q <= '0;
      r_b_q <= '0;
    end else begin
      if (w_a_rd) begin
        if (!w_a_we || RDW_MODE == 0) r_a_q <= w_a_old;
        else if (RDW_MODE == 1)       r_a_q <= w_a_final;
      end
      if (w_b_rd) begin
        if (!w_b_we || RDW_MODE == 0) r_b_q <= w_b_old;
        else if (RDW_MODE == 1)       r_b_q <= w_b_final;
      end
    end
  end

  if (OUTREG != 0) begin : g_outreg
    logic [DW-1:0] r_a_p, r_b_p;

    always_ff @(posedge i_MCLK or posedge i_RST) begin
      if (i_RST) begin
        r_a_p <= '0;
        r_b_p <= '0;
      end else begin
        r_a_p <= r_a_q;
        r_b_p <= r_b_q;
      end
    end

    assign o_A_DOUT = r_a_p;
    assign o_B_DOUT = r_b_p;
  end else begin : g_noreg
    assign o_A_DOUT = r_a_q;
    assign o_B_DOUT = r_b_q;
  end

  // Content preload from simhexfile is applied by the simulation environment onto r_mem.
  if (simhexfile != "") begin : g_simhex
  end

endmodule

// File: tb/tb_salamander_dpram_be.sv
// Directed bench for salamander_dpram_be: four instances (RDW modes 0/1/2, OUTREG=1) share one stimulus.
// Clear-engine checks follow SALAMANDER_DPRAM_CLEAR_EN.
module tb_salamander_dpram_be;

`ifdef SALAMANDER_DPRAM_CLEAR_EN
  localparam int  CLR_CYC  = 16;
  localparam logic EXP_BUSY = 1'b1;
`else
  localparam int  CLR_CYC  = 0;
  localparam logic EXP_BUSY = 1'b0;
`endif

  logic        clk, rst;
  logic [3:0]  a_addr, b_addr;
  logic [15:0] a_din, b_din;
  logic [1:0]  a_be, b_be;
  logic        a_rd, a_wr, b_rd, b_wr, clr_req;
  logic [15:0] a_dout0, b_dout0, a_dout1, b_dout1, a_dout2, b_dout2, a_dout3, b_dout3;
  logic        busy0, busy1, busy2, busy3;

  int n_checks;
  int n_fail;

  salamander_dpram_be #(.AW(4), .DW(16), .RDW_MODE(0), .OUTREG(0), .CLR_VAL(16'h5A5A)) u_m0 (
    .i_MCLK(clk), .i_RST(rst),
    .i_A_ADDR(a_addr), .i_A_DIN(a_din), .i_A_BE(a_be), .i_A_RD(a_rd), .i_A_WR(a_wr), .o_A_DOUT(a_dout0),
    .i_B_ADDR(b_addr), .i_B_DIN(b_din), .i_B_BE(b_be), .i_B_RD(b_rd), .i_B_WR(b_wr), .o_B_DOUT(b_dout0),
    .i_CLR_REQ(clr_req), .o_BUSY(busy0));

  salamander_dpram_be #(.AW(4), .DW(16), .RDW_MODE(1), .OUTREG(0), .CLR_VAL(16'h5A5A)) u_m1 (
    .i_MCLK(clk), .i_RST(rst),
    .i_A_ADDR(a_addr), .i_A_DIN(a_din), .i_A_BE(a_be), .i_A_RD(a_rd), .i_A_WR(a_wr), .o_A_DOUT(a_dout1),
    .i_B_ADDR(b_addr), .i_B_DIN(b_din), .i_B_BE(b_be), .i_B_RD(b_rd), .i_B_WR(b_wr), .o_B_DOUT(b_dout1),
    .i_CLR_REQ(clr_req), .o_BUSY(busy1));

  salamander_dpram_be #(.AW(4), .DW(16), .RDW_MODE(2), .OUTREG(0), .CLR_VAL(16'h5A5A)) u_m2 (
    .i_MCLK(clk), .i_RST(rst),
    .i_A_ADDR(a_addr), .i_A_DIN(a_din), .i_A_BE(a_be), .i_A_RD(a_rd), .i_A_WR(a_wr), .o_A_DOUT(a_dout2),
    .i_B_ADDR(b_addr), .i_B_DIN(b_din), .i_B_BE(b_be), .i_B_RD(b_rd), .i_B_WR(b_wr), .o_B_DOUT(b_dout2),
    .i_CLR_REQ(clr_req), .o_BUSY(busy2));

  salamander_dpram_be #(.AW(4), .DW(16), .RDW_MODE(2), .OUTREG(1), .CLR_VAL(16'h5A5A)) u_or (
    .i_MCLK(clk), .i_RST(rst),
    .i_A_ADDR(a_addr), .i_A_DIN(a_din), .i_A_BE(a_be), .i_A_RD(a_rd), .i_A_WR(a_wr), .o_A_DOUT(a_dout3),
    .i_B_ADDR(b_addr), .i_B_DIN(b_din), .i_B_BE(b_be), .i_B_RD(b_rd), .i_B_WR(b_wr), .o_B_DOUT(b_dout3),
    .i_CLR_REQ(clr_req), .o_BUSY(busy3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    a_rd = 1'b0; a_wr = 1'b0; b_rd = 1'b0; b_wr = 1'b0; clr_req = 1'b0;
    a_din = '0; b_din = '0; a_be = '0; b_be = '0;
  endtask

  task automatic test_reset;
    int n;
    rst = 1'b1;
    a_addr = '0; b_addr = '0;
    idle();
    tick(); tick();
    n_checks++;
    if (a_dout0 !== 16'h0000 || b_dout0 !== 16'h0000) begin
      n_fail++; $display("FAIL reset_dout: got a=%h b=%h expected 0000", a_dout0, b_dout0);
    end
    n_checks++;
    if (a_dout3 !== 16'h0000 || b_dout3 !== 16'h0000) begin
      n_fail++; $display("FAIL reset_dout_outreg: got a=%h b=%h expected 0000", a_dout3, b_dout3);
    end
    n_checks++;
    if (busy0 !== EXP_BUSY || busy3 !== EXP_BUSY) begin
      n_fail++; $display("FAIL reset_busy: got %b/%b expected %b", busy0, busy3, EXP_BUSY);
    end
    rst = 1'b0;
    n = 0;
    while (busy0 && n < 64) begin tick(); n++; end
    n_checks++;
    if (n !== CLR_CYC) begin
      n_fail++; $display("FAIL reset_busy_len: got %0d cycles expected %0d", n, CLR_CYC);
    end
  endtask

  task automatic test_basic;
    a_addr = 4'd3; a_din = 16'hBEEF; a_be = 2'b11; a_wr = 1'b1;
    tick();
    idle(); a_rd = 1'b1;
    tick();
    n_checks++;
    if (a_dout0 !== 16'hBEEF) begin
      n_fail++; $display("FAIL basic_read: got %h expected BEEF", a_dout0);
    end
    n_checks++;
    if (a_dout3 !== 16'h0000) begin
      n_fail++; $display("FAIL outreg_lat1: got %h expected 0000", a_dout3);
    end
    idle();
    tick();
    n_checks++;
    if (a_dout3 !== 16'hBEEF) begin
      n_fail++; $display("FAIL outreg_lat2: got %h expected BEEF", a_dout3);
    end
    n_checks++;
    if (a_dout0 !== 16'hBEEF) begin
      n_fail++; $display("FAIL read_hold: got %h expected BEEF", a_dout0);
    end
  endtask

  task automatic test_byte_lanes;
    a_addr = 4'd5; a_din = 16'h1234; a_be = 2'b11; a_wr = 1'b1;
    tick();
    a_din = 16'hABCD; a_be = 2'b10;
    tick();
    idle(); a_rd = 1'b1; b_addr = 4'd5; b_rd = 1'b1;
    tick();
    idle();
    n_checks++;
    if (a_dout0 !== 16'hAB34) begin
      n_fail++; $display("FAIL lane_a: got %h expected AB34", a_dout0);
    end
    n_checks++;
    if (b_dout0 !== 16'hAB34 || b_dout2 !== 16'hAB34) begin
      n_fail++; $display("FAIL lane_b: got %h/%h expected AB34", b_dout0, b_dout2);
    end
  endtask

  task automatic test_rdw;
    a_addr = 4'd7; a_din = 16'h1111; a_be = 2'b11; a_wr = 1'b1;
    tick();
    a_din = 16'h2222; a_rd = 1'b1;
    tick();
    idle();
    n_checks++;
    if (a_dout0 !== 16'h1111) begin
      n_fail++; $display("FAIL rdw_mode0: got %h expected 1111", a_dout0);
    end
    n_checks++;
    if (a_dout1 !== 16'h2222) begin
      n_fail++; $display("FAIL rdw_mode1: got %h expected 2222", a_dout1);
    end
    n_checks++;
    if (a_dout2 !== 16'hAB34) begin
      n_fail++; $display("FAIL rdw_mode2: got %h expected AB34", a_dout2);
    end
    a_rd = 1'b1;
    tick();
    idle();
    n_checks++;
    if (a_dout2 !== 16'h2222) begin
      n_fail++; $display("FAIL rdw_after: got %h expected 2222", a_dout2);
    end
  endtask

  task automatic test_collision;
    a_addr = 4'd9; a_din = 16'hAAAA; a_be = 2'b01; a_wr = 1'b1;
    b_addr = 4'd9; b_din = 16'hBBBB; b_be = 2'b11; b_wr = 1'b1;
    tick();
    idle(); a_rd = 1'b1;
    tick();
    n_checks++;
    if (a_dout0 !== 16'hBBAA) begin
      n_fail++; $display("FAIL collide_ww: got %h expected BBAA", a_dout0);
    end
    idle();
    a_din = 16'hCCCC; a_be = 2'b11; a_wr = 1'b1; b_rd = 1'b1;
    tick();
    n_checks++;
    if (b_dout0 !== 16'hBBAA || b_dout1 !== 16'hBBAA) begin
      n_fail++; $display("FAIL collide_wr: got %h/%h expected BBAA", b_dout0, b_dout1);
    end
    idle(); a_din = 16'h0000; a_be = 2'b00; a_wr = 1'b1;
    tick();
    idle(); a_rd = 1'b1;
    tick();
    n_checks++;
    if (a_dout0 !== 16'hCCCC) begin
      n_fail++; $display("FAIL noop_write: got %h expected CCCC", a_dout0);
    end
    idle();
    a_addr = 4'd1; a_din = 16'h0101; a_be = 2'b11; a_wr = 1'b1;
    b_addr = 4'd2; b_din = 16'h0202; b_be = 2'b11; b_wr = 1'b1;
    tick();
    idle(); a_addr = 4'd2; a_rd = 1'b1; b_addr = 4'd1; b_rd = 1'b1;
    tick();
    n_checks++;
    if (a_dout0 !== 16'h0202 || b_dout0 !== 16'h0101) begin
      n_fail++; $display("FAIL dual_write: got a=%h b=%h expected 0202/0101", a_dout0, b_dout0);
    end
    idle(); a_addr = 4'd9; a_rd = 1'b1;
    tick();
    idle();
    n_checks++;
    if (a_dout0 !== 16'hCCCC) begin
      n_fail++; $display("FAIL reread9: got %h expected CCCC", a_dout0);
    end
  endtask

  task automatic test_clear;
    int n;
`ifdef SALAMANDER_DPRAM_CLEAR_EN
    clr_req = 1'b1;
    tick();
    n_checks++;
    if (busy0 !== 1'b1 || busy3 !== 1'b1) begin
      n_fail++; $display("FAIL clr_start: got %b/%b expected 1", busy0, busy3);
    end
    a_addr = 4'd3; a_din = 16'h1111; a_be = 2'b11; a_wr = 1'b1; a_rd = 1'b1;
    n = 0;
    while (busy0 && n < 64) begin tick(); n++; end
    idle();
    n_checks++;
    if (n !== 16) begin
      n_fail++; $display("FAIL clr_len: got %0d cycles expected 16", n);
    end
    n_checks++;
    if (a_dout0 !== 16'hCCCC || a_dout3 !== 16'hCCCC) begin
      n_fail++; $display("FAIL clr_dout_hold: got %h/%h expected CCCC", a_dout0, a_dout3);
    end
    for (int i = 0; i < 16; i++) begin
      a_addr = 4'(i); b_addr = 4'(15 - i); a_rd = 1'b1; b_rd = 1'b1;
      tick();
      n_checks++;
      if (a_dout0 !== 16'h5A5A || b_dout0 !== 16'h5A5A) begin
        n_fail++; $display("FAIL clr_content[%0d]: got %h/%h expected 5A5A", i, a_dout0, b_dout0);
      end
    end
    idle();
    clr_req = 1'b1;
    tick();
    idle();
    for (int i = 0; i < 8; i++) tick();
    rst = 1'b1;
    tick();
    n_checks++;
    if (busy0 !== 1'b1 || a_dout0 !== 16'h0000) begin
      n_fail++; $display("FAIL clr_midreset: got busy=%b dout=%h expected 1/0000", busy0, a_dout0);
    end
    rst = 1'b0;
    n = 0;
    while (busy0 && n < 64) begin tick(); n++; end
    n_checks++;
    if (n !== 16) begin
      n_fail++; $display("FAIL clr_restart_len: got %0d cycles expected 16", n);
    end
`else
    clr_req = 1'b1;
    tick();
    idle();
    n = 0;
    tick();
    n_checks++;
    if (busy0 !== 1'b0 || busy3 !== 1'b0) begin
      n_fail++; $display("FAIL clr_absent_busy: got %b/%b expected 0", busy0, busy3);
    end
    a_addr = 4'd9; a_rd = 1'b1;
    tick();
    idle();
    n_checks++;
    if (a_dout0 !== 16'hCCCC) begin
      n_fail++; $display("FAIL clr_absent_content: got %h expected CCCC", a_dout0);
    end
`endif
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_basic();
    test_byte_lanes();
    test_rdw();
    test_collision();
    test_clear();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
